wb_write_scheduler: RTL and testbench

//  Write-side initiator for the CPU register file: merges single-cycle WB-stage results (port A) and

---
 rtl/wb_write_scheduler_if.sv | 41 ++++
 rtl/wb_write_scheduler.sv | 105 ++++++++++
 tb/tb_wb_write_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_scheduler_if.sv
// Bundle of request, response and scoreboard signals between decode/execute and the
// register-file write scheduler.
interface wb_write_scheduler_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid_i;
    logic [AW-1:0] a_addr_i;
    logic [DW-1:0] a_data_i;
    logic          b_valid_i;
    logic          b_ready_o;
    logic [AW-1:0] b_addr_i;
    logic [DW-1:0] b_data_i;
    logic          iss_valid_i;
    logic [AW-1:0] iss_addr_i;
    logic          iss_ready_o;
    logic [AW-1:0] RSaddr_i;
    logic [AW-1:0] RTaddr_i;
    logic          rs_busy_o;
    logic          rt_busy_o;
    logic [AW-1:0] RDaddr_o;
    logic [DW-1:0] RDdata_o;
    logic          RegWrite_o;
    logic          waw_err_o;

    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        output iss_valid_i, iss_addr_i, RSaddr_i, RTaddr_i,
        input  b_ready_o, iss_ready_o, rs_busy_o, rt_busy_o,
        input  RDaddr_o, RDdata_o, RegWrite_o, waw_err_o
    );

    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        input  iss_valid_i, iss_addr_i, RSaddr_i, RTaddr_i,
        output b_ready_o, iss_ready_o, rs_busy_o, rt_busy_o,
        output RDaddr_o, RDdata_o, RegWrite_o, waw_err_o
    );
endinterface

// File: rtl/wb_write_scheduler.sv
// Merges WB-stage writes (port A, priority) with buffered long-latency results (port B)
// onto one register-file write port, and tracks registers with outstanding long-latency writes.
module wb_write_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_write_scheduler_if.slave   bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << AW;

    logic [AW-1:0]   r_fifo_addr [DEPTH];
    logic [DW-1:0]   r_fifo_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW:0]     r_count;
    logic [NREG-1:0] r_pending;
    logic            r_regwrite;
    logic [AW-1:0]   r_rdaddr;
    logic [DW-1:0]   r_rddata;
    logic            r_waw_err;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_iss_set;
    logic            w_waw;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;
    logic            w_sel_vld;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [NREG-1:0] w_pending_nxt;

    assign w_full      = (r_count == (PW+1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = bus.b_valid_i & ~w_full;
    assign w_pop       = ~bus.a_valid_i & ~w_empty;
    assign w_iss_set   = bus.iss_valid_i & ~r_pending[bus.iss_addr_i] & (bus.iss_addr_i != '0);
    assign w_waw       = bus.a_valid_i & r_pending[bus.a_addr_i] & (bus.a_addr_i != '0);
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Port A always wins; a FIFO entry is only popped when A is idle.
    assign w_sel_vld  = bus.a_valid_i | w_pop;
    assign w_sel_addr = bus.a_valid_i ? bus.a_addr_i : w_head_addr;
    assign w_sel_data = bus.a_valid_i ? bus.a_data_i : w_head_data;

    // Clear first, then set, so a same-edge issue to the retiring address stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop)
            w_pending_nxt[w_head_addr] = 1'b0;
        if (w_iss_set)
            w_pending_nxt[bus.iss_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.b_addr_i;
            r_fifo_data[r_wr_ptr] <= bus.b_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_regwrite <= 1'b0;
            r_rdaddr   <= '0;
            r_rddata   <= '0;
            r_waw_err  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count   <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_pending <= w_pending_nxt;
            if (w_waw)
                r_waw_err <= 1'b1;
            // Writes to r0 are consumed but never reach the register file.
            r_regwrite <= w_sel_vld & (w_sel_addr != '0);
            if (w_sel_vld && (w_sel_addr != '0)) begin
                r_rdaddr <= w_sel_addr;
                r_rddata <= w_sel_data;
            end
        end
    end

    assign bus.b_ready_o   = ~w_full;
    assign bus.iss_ready_o = ~r_pending[bus.iss_addr_i];
    assign bus.rs_busy_o   = r_pending[bus.RSaddr_i];
    assign bus.rt_busy_o   = r_pending[bus.RTaddr_i];
    assign bus.RDaddr_o    = r_rdaddr;
    assign bus.RDdata_o    = r_rddata;
    assign bus.RegWrite_o  = r_regwrite;
    assign bus.waw_err_o   = r_waw_err;
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Randomized and directed bench for wb_write_scheduler against a queue-based reference model.
module tb_wb_write_scheduler;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk_i;
    logic rst_i;
    wb_write_scheduler_if #(.AW(AW), .DW(DW)) bus ();

    wb_write_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    ent_t          m_q[$];
    bit            pend[1 << AW];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_waw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_waw  = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.a_valid_i   = 1'b0;
        bus.a_addr_i    = '0;
        bus.a_data_i    = '0;
        bus.b_valid_i   = 1'b0;
        bus.b_addr_i    = '0;
        bus.b_data_i    = '0;
        bus.iss_valid_i = 1'b0;
        bus.iss_addr_i  = '0;
        bus.RSaddr_i    = '0;
        bus.RTaddr_i    = '0;
    endtask

    // Called just after a negedge with inputs set; checks combinational outputs,
    // advances the model one clock, checks registered outputs, returns at next negedge.
    task automatic step();
        bit   acc;
        bit   iss_set;
        ent_t e;
        #1;
        check("b_ready",   bus.b_ready_o,   m_q.size() < DEPTH);
        check("iss_ready", bus.iss_ready_o, !pend[bus.iss_addr_i]);
        check("rs_busy",   bus.rs_busy_o,   pend[bus.RSaddr_i]);
        check("rt_busy",   bus.rt_busy_o,   pend[bus.RTaddr_i]);
        acc     = bus.b_valid_i && (m_q.size() < DEPTH);
        iss_set = bus.iss_valid_i && !pend[bus.iss_addr_i] && (bus.iss_addr_i != 0);
        if (bus.a_valid_i) begin
            if (bus.a_addr_i != 0 && pend[bus.a_addr_i]) m_waw = 1'b1;
            m_we = (bus.a_addr_i != 0);
            if (m_we) begin
                m_addr = bus.a_addr_i;
                m_data = bus.a_data_i;
            end
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = (e.a != 0);
            if (m_we) begin
                m_addr = e.a;
                m_data = e.d;
            end
            pend[e.a] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (acc) m_q.push_back('{bus.b_addr_i, bus.b_data_i});
        if (iss_set) pend[bus.iss_addr_i] = 1'b1;
        @(posedge clk_i);
        #1;
        check("RegWrite", bus.RegWrite_o, m_we);
        if (m_we) begin
            check("RDaddr", bus.RDaddr_o, m_addr);
            check("RDdata", bus.RDdata_o, m_data);
        end
        check("waw_err", bus.waw_err_o, m_waw);
        @(negedge clk_i);
    endtask

    initial begin
        int bi;
        bit acc;
        rst_i = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_RegWrite", bus.RegWrite_o, 1'b0);
        check("rst_RDaddr",   bus.RDaddr_o,   '0);
        check("rst_RDdata",   bus.RDdata_o,   '0);
        check("rst_waw",      bus.waw_err_o,  1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst_b_ready",   bus.b_ready_o,   1'b1);
        check("rst_iss_ready", bus.iss_ready_o, 1'b1);
        @(negedge clk_i);

        // Port A single write, then idle
        bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd5; bus.a_data_i = 32'h1234;
        step();
        idle_inputs();
        step();

        // Issue r8, then its B result with A idle; busy tracked via RSaddr
        bus.iss_valid_i = 1'b1; bus.iss_addr_i = 5'd8; bus.RSaddr_i = 5'd8;
        step();
        bus.iss_valid_i = 1'b0;
        bus.b_valid_i = 1'b1; bus.b_addr_i = 5'd8; bus.b_data_i = 32'hCAFE;
        step();
        bus.b_valid_i = 1'b0;
        check("r8_busy_before_write", bus.rs_busy_o, 1'b1);
        step();
        check("r8_busy_after_write", bus.rs_busy_o, 1'b0);
        check("r8_written", bus.RDdata_o, 32'hCAFE);
        step();

        // A busy for 6 cycles while B offers 6 results; source holds until accepted
        bi = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.a_valid_i = (cyc < 6);
            bus.a_addr_i  = 5'(1 + cyc);
            bus.a_data_i  = 32'hA000 + cyc;
            bus.b_valid_i = (bi < 6);
            bus.b_addr_i  = 5'(12 + bi);
            bus.b_data_i  = 32'hB000 + bi;
            acc = bus.b_valid_i && (m_q.size() < DEPTH);
            step();
            if (acc) bi++;
        end
        check("fifo_all_accepted", bi, 6);
        idle_inputs();

        // Address 0 on both ports
        bus.a_valid_i = 1'b1; bus.a_addr_i = '0; bus.a_data_i = 32'hDEAD;
        bus.b_valid_i = 1'b1; bus.b_addr_i = '0; bus.b_data_i = 32'hBEEF;
        step();
        idle_inputs();
        step();
        step();
        check("addr0_fifo_empty", bus.b_ready_o, 1'b1);

        // Double issue of r3, then WAW by port A
        bus.iss_valid_i = 1'b1; bus.iss_addr_i = 5'd3;
        step();
        step();
        bus.iss_valid_i = 1'b0;
        bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd3; bus.a_data_i = 32'h3333;
        step();
        idle_inputs();
        step();
        step();

        // Randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.a_valid_i   = ($urandom_range(0, 2) == 0);
            bus.a_addr_i    = 5'($urandom_range(0, 9));
            bus.a_data_i    = $urandom;
            bus.b_valid_i   = ($urandom_range(0, 1) == 0);
            bus.b_addr_i    = 5'($urandom_range(0, 9));
            bus.b_data_i    = $urandom;
            bus.iss_valid_i = ($urandom_range(0, 2) == 0);
            bus.iss_addr_i  = 5'($urandom_range(0, 9));
            bus.RSaddr_i    = 5'($urandom_range(0, 9));
            bus.RTaddr_i    = 5'($urandom_range(0, 9));
            step();
        end
        idle_inputs();
        for (int cyc = 0; cyc < 6; cyc++) step();

        // Reset mid-operation: 3 FIFO entries, 2 pending, write in flight
        bus.iss_valid_i = 1'b1; bus.iss_addr_i = 5'd10;
        step();
        bus.iss_addr_i = 5'd11;
        step();
        bus.iss_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.a_valid_i = 1'b1; bus.a_addr_i = 5'd20; bus.a_data_i = 32'h2000 + k;
            bus.b_valid_i = 1'b1; bus.b_addr_i = 5'(10 + (k % 2)); bus.b_data_i = 32'hC000 + k;
            step();
        end
        idle_inputs();
        bus.RSaddr_i = 5'd10;
        bus.RTaddr_i = 5'd11;
        check("pre_rst_RegWrite", bus.RegWrite_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_rst_RegWrite", bus.RegWrite_o, 1'b0);
        check("mid_rst_RDaddr",   bus.RDaddr_o,   '0);
        check("mid_rst_rs_busy",  bus.rs_busy_o,  1'b0);
        check("mid_rst_rt_busy",  bus.rt_busy_o,  1'b0);
        check("mid_rst_b_ready",  bus.b_ready_o,  1'b1);
        check("mid_rst_waw",      bus.waw_err_o,  1'b0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) step();
        for (int cyc = 0; cyc < 50; cyc++) begin
            bus.a_valid_i   = ($urandom_range(0, 1) == 0);
            bus.a_addr_i    = 5'($urandom);
            bus.a_data_i    = $urandom;
            bus.b_valid_i   = ($urandom_range(0, 1) == 0);
            bus.b_addr_i    = 5'($urandom);
            bus.b_data_i    = $urandom;
            bus.iss_valid_i = ($urandom_range(0, 1) == 0);
            bus.iss_addr_i  = 5'($urandom);
            bus.RSaddr_i    = 5'($urandom);
            bus.RTaddr_i    = 5'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
